lfsr_fifo_ctrl: RTL and testbench

- Sequencing controller between the Galois LFSR, the 16-deep FIFO and the board I/O (slide switch, push button).
- Synchronizes the switch and synchronizes plus debounces the button.
- Runs a fill FSM that enables the LFSR and pushes its output into the FIFO only while there is room, with hysteresis on FIFO occupancy.
- Turns each debounced button press into exactly one FIFO pop, and tracks FIFO occupancy for status.

---
 rtl/lfsr_fifo_ctrl_pkg.sv | 12 +
 rtl/lfsr_fifo_ctrl_checker.sv | 47 ++++
 rtl/lfsr_fifo_ctrl_debounce.sv | 71 +++++++
 rtl/lfsr_fifo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lfsr_fifo_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_fifo_ctrl_pkg.sv
// Shared FSM encodings and sizing helpers for the LFSR/FIFO sequencing controller.
package lfsr_fifo_ctrl_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lfsr_fifo_ctrl_checker.sv
// Occupancy and button-strobe invariants for the sequencing controller.
module lfsr_fifo_ctrl_checker #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = 5
) (
    input logic               clk,
    input logic               reset_n,
    input logic               push,
    input logic               pop,
    input logic [LEVEL_W-1:0] level,
    input logic               fifo_full,
    input logic               fifo_empty,
    input logic               btn_stable,
    input logic               btn_rise,
    input logic               btn_fall
);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO = {LEVEL_W{1'b0}};

    logic quiet_r;

    // Flags only settle against level after a cycle with no data movement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quiet_r <= 1'b0;
        end else begin
            quiet_r <= ~push & ~pop;
        end
    end

    a_level_max: assert property (@(posedge clk) disable iff (!reset_n)
        level <= LEVEL_FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        (pop && !push) |-> (level != LEVEL_ZERO));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push && !pop) |-> (level != LEVEL_FULL));
    a_empty_match: assert property (@(posedge clk) disable iff (!reset_n)
        quiet_r |-> ((level == LEVEL_ZERO) == fifo_empty));
    a_full_match: assert property (@(posedge clk) disable iff (!reset_n)
        quiet_r |-> ((level == LEVEL_FULL) == fifo_full));
    a_edge_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(btn_rise && btn_fall));
    a_rise_stable: assert property (@(posedge clk) disable iff (!reset_n)
        btn_rise |-> btn_stable);

endmodule

// File: rtl/lfsr_fifo_ctrl_debounce.sv
// Synchronizes an asynchronous button and accepts a new level only after it
// has been stable for DEBOUNCE_CYCLES consecutive cycles.
module lfsr_fifo_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   stable_d_r;
    logic                   rise_r;
    logic                   fall_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Metastability synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Stability counter; any return to the accepted value restarts the wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else if (sync_s == stable_r) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= stable_r;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= ~stable_r;
        end else begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            stable_r <= stable_r;
        end
    end

    // Registered edge strobes of the accepted value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_r <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
            rise_r     <= stable_r & ~stable_d_r;
            fall_r     <= ~stable_r & stable_d_r;
        end
    end

    assign stable     = stable_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

endmodule

// File: rtl/lfsr_fifo_ctrl.sv
// Sequences LFSR output into the FIFO with occupancy hysteresis and turns
// debounced button presses into single FIFO pops.
module lfsr_fifo_ctrl
    import lfsr_fifo_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int LOW_WATER       = 4,
    localparam int LEVEL_W        = level_width(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fill_req,
    input  logic               pop_btn,
    input  logic               lfsr_valid,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               lfsr_enable,
    output logic               fifo_push,
    output logic               fifo_pop,
    output logic               pop_dropped,
    output logic [LEVEL_W-1:0] level,
    output logic               filling
);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL   = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_ALMOST = LEVEL_W'(FIFO_DEPTH - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_LOW    = LEVEL_W'(LOW_WATER);
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO   = {LEVEL_W{1'b0}};
    localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);

    logic [SYNC_STAGES-1:0] fill_sync_r;
    logic                   fill_sync_s;
    logic [0:0]             state_r;
    logic [0:0]             state_nxt_s;
    logic                   in_fill_s;
    logic                   push_s;
    logic                   fifo_pop_r;
    logic                   pop_dropped_r;
    logic [LEVEL_W-1:0]     level_r;
    logic                   btn_stable_s;
    logic                   btn_rise_s;
    logic                   btn_fall_s;

    lfsr_fifo_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (pop_btn),
        .stable     (btn_stable_s),
        .rise_pulse (btn_rise_s),
        .fall_pulse (btn_fall_s)
    );

    // Switch synchronizer; the switch needs no debounce, only clean sampling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            fill_sync_r <= {fill_sync_r[SYNC_STAGES-2:0], fill_req};
        end
    end

    assign fill_sync_s = fill_sync_r[SYNC_STAGES-1];
    assign in_fill_s   = (state_r == ST_FILL);
    // LFSR stalls while full so no generated word is ever lost
    assign push_s      = in_fill_s & lfsr_valid & ~fifo_full;

    // Fill FSM next-state with low-water hysteresis and early exit on last push
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_sync_s && (level_r <= LEVEL_LOW)) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!fill_sync_s || (level_r == LEVEL_FULL) ||
                    ((level_r == LEVEL_ALMOST) && push_s && !fifo_pop_r)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // One pop (or a drop report) per accepted press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_pop_r    <= 1'b0;
            pop_dropped_r <= 1'b0;
        end else begin
            fifo_pop_r    <= btn_rise_s & ~fifo_empty;
            pop_dropped_r <= btn_rise_s & fifo_empty;
        end
    end

    // Saturating occupancy counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= LEVEL_ZERO;
        end else begin
            case ({push_s, fifo_pop_r})
                2'b10: begin
                    if (level_r != LEVEL_FULL) begin
                        level_r <= level_r + LEVEL_ONE;
                    end else begin
                        level_r <= level_r;
                    end
                end
                2'b01: begin
                    if (level_r != LEVEL_ZERO) begin
                        level_r <= level_r - LEVEL_ONE;
                    end else begin
                        level_r <= level_r;
                    end
                end
                default: level_r <= level_r;
            endcase
        end
    end

    assign lfsr_enable = in_fill_s & ~fifo_full;
    assign fifo_push   = push_s;
    assign fifo_pop    = fifo_pop_r;
    assign pop_dropped = pop_dropped_r;
    assign level       = level_r;
    assign filling     = in_fill_s;

    lfsr_fifo_ctrl_checker #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEVEL_W    (LEVEL_W)
    ) u_checker (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_s),
        .pop        (fifo_pop_r),
        .level      (level_r),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .btn_stable (btn_stable_s),
        .btn_rise   (btn_rise_s),
        .btn_fall   (btn_fall_s)
    );

endmodule

// File: tb/tb_lfsr_fifo_ctrl.sv
// Scoreboard bench for lfsr_fifo_ctrl with a behavioural FIFO occupancy model.
module tb_lfsr_fifo_ctrl;

    localparam int DB        = 4;
    localparam int SS        = 2;
    localparam int DEPTH     = 16;
    localparam int LWM       = 4;
    localparam int KIND_POP  = 0;
    localparam int KIND_DROP = 1;
    localparam int PRESS_LAT = SS + DB + 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fill_req;
    logic       pop_btn;
    logic       lfsr_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       lfsr_enable;
    logic       fifo_push;
    logic       fifo_pop;
    logic       pop_dropped;
    logic [4:0] level;
    logic       filling;

    int  cyc      = 0;
    int  fcnt     = 0;
    int  push_cnt = 0;
    int  checks   = 0;
    int  errors   = 0;
    ev_t exp_q[$];

    lfsr_fifo_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .FIFO_DEPTH      (DEPTH),
        .LOW_WATER       (LWM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fill_req    (fill_req),
        .pop_btn     (pop_btn),
        .lfsr_valid  (lfsr_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .lfsr_enable (lfsr_enable),
        .fifo_push   (fifo_push),
        .fifo_pop    (fifo_pop),
        .pop_dropped (pop_dropped),
        .level       (level),
        .filling     (filling)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO occupancy model, reset together with the controller
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) fcnt <= 0;
        else          fcnt <= fcnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end

    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    // Scoreboard: match every pop/drop strobe against the expected queue
    initial begin : monitor
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            if (fifo_push) push_cnt++;
            if (fifo_pop || pop_dropped) begin
                kind = fifo_pop ? KIND_POP : KIND_DROP;
                checks++;
                if (fifo_pop && pop_dropped) begin
                    errors++;
                    $display("FAIL sb_both_strobes pop=1 drop=1 required exactly one");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected kind=%0d cyc=%0d required no event", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e.kind || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL sb_event kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                                 kind, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int kind);
        ev_t e;
        pop_btn = 1'b1;
        e.kind  = kind;
        e.cyc   = cyc + PRESS_LAT;
        exp_q.push_back(e);
        tick(10);
        pop_btn = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        fill_req   = 1'b0;
        pop_btn    = 1'b0;
        lfsr_valid = 1'b0;
        #3;
        checks++;
        if ({lfsr_enable, fifo_push, fifo_pop, pop_dropped, filling} !== 5'b00000 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs en/push/pop/drop/fill=%b level=%0d required 00000 level=0",
                     {lfsr_enable, fifo_push, fifo_pop, pop_dropped, filling}, level);
        end
        tick(3);
        reset_n = 1'b1;
        tick(6);
        checks++;
        if (filling !== 1'b0 || level !== 5'd0 || lfsr_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req filling=%b level=%0d en=%b required 0 0 0", filling, level, lfsr_enable);
        end
    endtask

    task automatic test_drop();
        press(KIND_DROP);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drop_missing pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (level !== 5'd0 || filling !== 1'b0) begin
            errors++;
            $display("FAIL drop_level level=%0d filling=%b required 0 0", level, filling);
        end
    endtask

    task automatic test_fill();
        int first = -1;
        int last  = -1;
        int n     = 0;
        int gaps  = 0;
        int start;
        start      = cyc;
        fill_req   = 1'b1;
        lfsr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (fifo_push) begin
                if (first < 0) first = cyc;
                else if (cyc != last + 1) gaps++;
                last = cyc;
                n++;
            end
        end
        checks++;
        if (n !== 16 || gaps !== 0) begin
            errors++;
            $display("FAIL fill_pushes count=%0d gaps=%0d required 16 0", n, gaps);
        end
        checks++;
        if (first !== start + SS + 1) begin
            errors++;
            $display("FAIL fill_start cyc=%0d required %0d", first, start + SS + 1);
        end
        checks++;
        if (filling !== 1'b0 || level !== 5'd16 || lfsr_enable !== 1'b0) begin
            errors++;
            $display("FAIL fill_done filling=%b level=%0d en=%b required 0 16 0", filling, level, lfsr_enable);
        end
    endtask

    task automatic test_pop_full();
        press(KIND_POP);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pop_full_missing pending=%0d required 0", exp_q.size());
        end
        checks++;
        if (level !== 5'd15 || filling !== 1'b0 || lfsr_enable !== 1'b0) begin
            errors++;
            $display("FAIL pop_full_state level=%0d filling=%b en=%b required 15 0 0", level, filling, lfsr_enable);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 2; k++) begin
            pop_btn = 1'b1;
            tick(2);
            pop_btn = 1'b0;
            tick(2);
        end
        press(KIND_POP);
        checks++;
        if (exp_q.size() !== 0 || level !== 5'd14) begin
            errors++;
            $display("FAIL bounce pending=%0d level=%0d required 0 14", exp_q.size(), level);
        end
    endtask

    task automatic test_refill();
        ev_t e;
        int  base;
        lfsr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            press(KIND_POP);
            if (i == 8) begin
                checks++;
                if (level !== 5'd5 || filling !== 1'b0) begin
                    errors++;
                    $display("FAIL above_low_water level=%0d filling=%b required 5 0", level, filling);
                end
            end
        end
        checks++;
        if (level !== 5'd4 || filling !== 1'b1 || lfsr_enable !== 1'b1) begin
            errors++;
            $display("FAIL low_water_entry level=%0d filling=%b en=%b required 4 1 1", level, filling, lfsr_enable);
        end
        pop_btn = 1'b1;
        e.kind  = KIND_POP;
        e.cyc   = cyc + PRESS_LAT;
        exp_q.push_back(e);
        tick(PRESS_LAT);
        base       = push_cnt;
        lfsr_valid = 1'b1;
        tick(1);
        checks++;
        if (level !== 5'd4) begin
            errors++;
            $display("FAIL push_pop_same_cycle level=%0d required 4", level);
        end
        for (int i = 0; i < 40; i++) begin
            if (!filling) break;
            tick(1);
        end
        pop_btn = 1'b0;
        tick(8);
        checks++;
        if (push_cnt - base !== 13 || level !== 5'd16 || filling !== 1'b0) begin
            errors++;
            $display("FAIL refill pushes=%0d level=%0d filling=%b required 13 16 0",
                     push_cnt - base, level, filling);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL refill_missing pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int found = 0;
        reset_n = 1'b0;
        tick(2);
        reset_n    = 1'b1;
        lfsr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (level == 5'd7) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found !== 1 || filling !== 1'b1) begin
            errors++;
            $display("FAIL burst_level7 found=%0d filling=%b required 1 1", found, filling);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({lfsr_enable, fifo_push, fifo_pop, pop_dropped, filling} !== 5'b00000 || level !== 5'd0) begin
            errors++;
            $display("FAIL async_reset en/push/pop/drop/fill=%b level=%0d required 00000 level=0",
                     {lfsr_enable, fifo_push, fifo_pop, pop_dropped, filling}, level);
        end
        tick(3);
        reset_n = 1'b1;
        tick(SS);
        checks++;
        if (filling !== 1'b0 || fifo_push !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_sync filling=%b push=%b required 0 0", filling, fifo_push);
        end
        tick(1);
        checks++;
        if (filling !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fill filling=%b required 1", filling);
        end
    endtask

    initial begin
        test_reset();
        test_drop();
        test_fill();
        test_pop_full();
        test_bounce();
        test_refill();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
